// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared widths, default depth and word type for data_memory
package data_memory_pkg;

    localparam int DATA_W        = 32;
    localparam int ADDR_W        = 32;
    localparam int DEFAULT_DEPTH = 256;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/data_memory_array.sv
// rtl/data_memory_array.sv - DEPTH x 32-bit register array, async clear, sync write, comb read
//
// Ports:
//   clk    rising-edge write clock
//   rst_n  asynchronous active-low clear of every word
//   we     write enable
//   addr   word index shared by the write and read ports
//   wdata  write data
//   rdata  combinational read of mem[addr]
import data_memory_pkg::*;

module data_memory_array #(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [DEPTH];

    // While rst_n is low the reset branch is taken on every event, so the
    // array stays cleared and any write on a coincident edge is discarded.
    // A non-1 enable (including X in simulation) takes no write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we == 1'b1) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - MEM-stage data memory: index decode, array, MemRead-gated read
//
// Optional build macro: DATA_MEMORY_BYTE_ADDR_EN (Address is a byte address,
// index taken from Address[AW+1:2]); default build treats Address as a word index.
//
// Ports:
//   clk         rising-edge write clock
//   rst         asynchronous active-low reset, clears every word
//   Address     address; only the index bits are used, the rest alias
//   Write_data  data stored on a write
//   MemWrite    write enable, sampled on the rising edge
//   MemRead     combinational read enable; Read_data is 0 when low
//   Read_data   read data
import data_memory_pkg::*;

module data_memory #(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Address,
    input  word_t             Write_data,
    input  logic              MemWrite,
    input  logic              MemRead,
    output word_t             Read_data
);

    logic [AW-1:0] idx;
    word_t         rd_word;
    logic          unused_addr_bits;

`ifdef DATA_MEMORY_BYTE_ADDR_EN
    // Byte addressing: low two bits select a byte within the word and are
    // ignored; there is no misalignment fault.
    assign idx              = Address[AW+1:2];
    assign unused_addr_bits = ^{Address[ADDR_W-1:AW+2], Address[1:0]};
`else
    assign idx              = Address[AW-1:0];
    assign unused_addr_bits = ^Address[ADDR_W-1:AW];
`endif

    data_memory_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst_n (rst),
        .we    (MemWrite),
        .addr  (idx),
        .wdata (Write_data),
        .rdata (rd_word)
    );

    // No write-through bypass: a same-cycle write shows up only after the edge.
    assign Read_data = MemRead ? rd_word : '0;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - table-driven and randomized self-checking bench for data_memory
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int DEPTH = DEFAULT_DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address;
    word_t       Write_data;
    logic        MemWrite;
    logic        MemRead;
    word_t       Read_data;

    int tests_run = 0;
    int tests_failed = 0;

    word_t mem_m [DEPTH];

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .Address    (Address),
        .Write_data (Write_data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Read_data  (Read_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    function automatic int midx(input logic [31:0] a);
`ifdef DATA_MEMORY_BYTE_ADDR_EN
        return int'((a / 4) % DEPTH);
`else
        return int'(a % DEPTH);
`endif
    endfunction

    function automatic logic [31:0] waddr(input int i);
`ifdef DATA_MEMORY_BYTE_ADDR_EN
        return 32'(i) * 4;
`else
        return 32'(i);
`endif
    endfunction

    function automatic word_t model_rd(input logic [31:0] a, input logic re);
        return re ? mem_m[midx(a)] : '0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic check(input string nm, input word_t got, input word_t exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, wanted %h", nm, got, exp);
        end
    endtask

    // One transaction: drive at negedge, check before the rising edge, check after it.
    task automatic apply(input logic [31:0] a, input word_t wd, input logic we, input logic re,
                         input word_t exp_pre, input word_t exp_post, input string nm);
        @(negedge clk);
        Address = a; Write_data = wd; MemWrite = we; MemRead = re;
        #1 check({nm, "_pre"}, Read_data, exp_pre);
        @(posedge clk);
        if (we && rst) mem_m[midx(a)] = wd;
        #1 check({nm, "_post"}, Read_data, exp_post);
    endtask

    typedef struct {
        logic [31:0] addr;
        word_t       wdata;
        logic        we;
        logic        re;
        word_t       exp_pre;
        word_t       exp_post;
    } vec_t;

    vec_t vecs [8];

    initial begin
        word_t       wd, epre, epost;
        logic [31:0] a;
        logic        we, re;

`ifdef DATA_MEMORY_BYTE_ADDR_EN
        vecs[0] = '{32'd0,   32'd11,          1'b1, 1'b1, 32'd0,          32'd11};
        vecs[1] = '{32'd4,   32'd0,           1'b0, 1'b1, 32'd0,          32'd0};
        vecs[2] = '{32'd8,   32'hA5A5_A5A5,   1'b1, 1'b0, 32'd0,          32'd0};
        vecs[3] = '{32'd8,   32'd0,           1'b0, 1'b1, 32'hA5A5_A5A5,  32'hA5A5_A5A5};
        vecs[4] = '{32'd9,   32'd0,           1'b0, 1'b1, 32'hA5A5_A5A5,  32'hA5A5_A5A5};
        vecs[5] = '{32'd11,  32'd0,           1'b0, 1'b1, 32'hA5A5_A5A5,  32'hA5A5_A5A5};
        vecs[6] = '{32'd12,  32'd0,           1'b0, 1'b1, 32'd0,          32'd0};
        vecs[7] = '{32'd1032, 32'd0,          1'b0, 1'b1, 32'hA5A5_A5A5,  32'hA5A5_A5A5};
`else
        vecs[0] = '{32'd0,   32'd11,          1'b1, 1'b1, 32'd0,          32'd11};
        vecs[1] = '{32'd1,   32'd0,           1'b0, 1'b1, 32'd0,          32'd0};
        vecs[2] = '{32'd3,   32'hDEAD_BEEF,   1'b1, 1'b0, 32'd0,          32'd0};
        vecs[3] = '{32'd3,   32'd0,           1'b0, 1'b1, 32'hDEAD_BEEF,  32'hDEAD_BEEF};
        vecs[4] = '{32'd5,   32'h1234_5678,   1'b1, 1'b1, 32'd0,          32'h1234_5678};
        vecs[5] = '{32'd261, 32'd0,           1'b0, 1'b1, 32'h1234_5678,  32'h1234_5678};
        vecs[6] = '{32'hFFFF_FF03, 32'd0,     1'b0, 1'b1, 32'hDEAD_BEEF,  32'hDEAD_BEEF};
        vecs[7] = '{32'd0,   32'd0,           1'b0, 1'b0, 32'd0,          32'd0};
`endif

        // Reset: output is 0 and a write during reset is blocked.
        rst = 1'b0; Address = 32'd0; Write_data = 32'd11; MemWrite = 1'b1; MemRead = 1'b1;
        model_clear();
        #1 check("reset_read", Read_data, 32'd0);
        @(posedge clk);
        #1 check("reset_write_blocked_in_reset", Read_data, 32'd0);
        @(negedge clk);
        rst = 1'b1; MemWrite = 1'b0;
        #1 check("reset_write_blocked_after", Read_data, 32'd0);

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re,
                  vecs[i].exp_pre, vecs[i].exp_post, $sformatf("vec%0d", i));
        end

        // Randomized traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = (a & 32'hFFFF_FC00) | 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            wd = $urandom;
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 3) != 0);
            epre  = model_rd(a, re);
            epost = (we && re) ? wd : epre;
            apply(a, wd, we, re, epre, epost, $sformatf("rand%0d", n));
        end

        // Fill every word with its own index, then reset between edges.
        for (int i = 0; i < DEPTH; i++) begin
            apply(waddr(i), word_t'(i), 1'b1, 1'b1, model_rd(waddr(i), 1'b1), word_t'(i),
                  $sformatf("fill%0d", i));
        end
        apply(waddr(7), 32'd0, 1'b0, 1'b1, 32'd7, 32'd7, "fill_readback7");

        @(negedge clk);
        Address = waddr(7); Write_data = 32'h0000_FFFF; MemWrite = 1'b1; MemRead = 1'b1;
        #2 rst = 1'b0;
        model_clear();
        #1 check("midreset_immediate", Read_data, 32'd0);
        for (int i = 0; i < DEPTH; i += 17) begin
            Address = waddr(i);
            #1 check($sformatf("in_reset_%0d", i), Read_data, 32'd0);
        end
        Address = waddr(7);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; MemWrite = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            Address = waddr(i);
            #1 check($sformatf("cleared_%0d", i), Read_data, 32'd0);
        end

        // First write right after reset release lands.
        apply(waddr(9), 32'hCAFE_0009, 1'b1, 1'b1, 32'd0, 32'hCAFE_0009, "post_release_write");
        apply(waddr(9), 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, "post_release_gated");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory for the single-cycle MIPS datapath, sitting behind the ALU address output in the MEM stage. It accepts a synchronous write and provides a combinational, read-enable-gated read, with the whole array cleared by an asynchronous active-low reset. A 32-bit address selects one 32-bit word.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; must be a power of two, at least 2.
- AW, $clog2(DEPTH): index width derived from DEPTH; not overridden.

Ports:
- clk  input  1  system clock; all writes on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clears every word to 0.
- Address  input  32  word address; only bits [AW-1:0] are used.
- Write_data  input  32  data stored on a write.
- MemWrite  input  1  write enable, sampled at the rising edge of clk.
- MemRead  input  1  read enable, combinational.
- Read_data  output  32  read data.

## Operation
- Storage is DEPTH × 32-bit registers, mem[0..DEPTH-1].
- Index: idx = Address[AW-1:0]. Bits [31:AW] are ignored, so addresses alias modulo DEPTH with no error flag.
- Write: at a rising clk edge with rst=1 and MemWrite=1, mem[idx] <= Write_data. All other words hold their value.
- Read: Read_data = MemRead ? mem[idx] : 32'h0000_0000. The read is purely combinational from Address, MemRead and array contents.
- MemRead=1 and MemWrite=1 together is legal. Read_data shows the old word until the edge, then the new word immediately after it. There is no write-through bypass.
- MemWrite with MemRead=0 still writes, and Read_data stays 0.
- Reset: while rst=0, every mem word is 0 and writes are blocked. Read_data is therefore 0 regardless of MemRead.
- Reset mid-operation: asserting rst clears the array immediately without waiting for clk. A write pending on the same edge is discarded.
- X/Z on MemWrite does not corrupt memory contents. Treat it as no write.

## Timing
- Write latency: data is visible on Read_data at the same index 0 cycles after the capturing edge. It appears after the edge, combinationally.
- Read latency: combinational, 0 cycles. Read_data settles within the same cycle as an Address or MemRead change.
- Reset release: the first write can occur on the first rising edge after rst returns to 1.
- Output value during reset: 0.

## Configuration
- Macro DATA_MEMORY_BYTE_ADDR_EN.
- When defined: Address is a byte address, and idx = Address[AW+1:2]. Address[1:0] is ignored, with no misalignment fault. Aliasing is modulo DEPTH words, i.e. 4·DEPTH bytes.
- When undefined (default): Address is a word index, and idx = Address[AW-1:0].
- All other behaviour is identical in both builds.

## Structure
- Shared package data_memory_pkg:
  - DATA_W = 32
  - ADDR_W = 32
  - DEFAULT_DEPTH = 256
  - the data word typedef
- Top module data_memory contains:
  - the index decode, including the macro-selected slice
  - the read mux with its MemRead gating
- One sub-module, data_memory_array, is natural. It holds the register array, the asynchronous clear and the synchronous write port, and exposes a combinational read port.

## Test plan
- Reset with rst=0, MemRead=1, Address=0 → Read_data=0. Then write 32'd11 to index 0, release rst, read index 0 → 0, confirming the write was blocked during reset.
- After reset, MemRead=1 and Address=0: Read_data=0. Set Write_data=11 and MemWrite=1 → Read_data=0 before the edge and 11 after it. Then MemWrite=0 and Address=1 → Read_data=0.
- Write 32'hDEAD_BEEF at address 3 with MemRead=0 → Read_data=0. Set MemRead=1 → Read_data=32'hDEAD_BEEF.
- Aliasing with DEPTH=256: write 32'h1234_5678 at address 5, then read address 261 → 32'h1234_5678.
- Fill addresses 0..DEPTH-1 with their own index, then pull rst low between clock edges → all words read 0 immediately. The write on the coincident edge is lost.
- Build with DATA_MEMORY_BYTE_ADDR_EN: write 32'hA5A5_A5A5 at address 8, then read addresses 8, 9 and 11 → all return 32'hA5A5_A5A5. Address 12 → 0.
